// File: rtl/axis_packetizer.sv
// axis_packetizer: cuts a raw AXI-Stream beat stream into tlast-framed packets tagged with packet IDs.
// Define AXIS_PACKETIZER_STATS_EN to add saturating packet / timeout-flush statistics counters.
module axis_packetizer #(
  parameter int DATA_WIDTH  = 32,
  parameter int TID_WIDTH   = 8,
  parameter int MAX_PKT_LEN = 16,
  parameter int LEN_WIDTH   = 5,
  parameter int TIMEOUT     = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [TID_WIDTH-1:0]  m_axis_tid
`ifdef AXIS_PACKETIZER_STATS_EN
  ,
  output logic [31:0]           stat_pkt_cnt,
  output logic [31:0]           stat_flush_cnt
`endif
);

  // Handshake rule on both sides: a transfer happens on a rising aclk edge where
  // tvalid && tready; once raised, tvalid holds with stable payload until that edge.

  localparam int                   IDLE_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0]    IDLE_LIMIT = IDLE_W'(TIMEOUT);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN    = LEN_WIDTH'(MAX_PKT_LEN);

  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0]  cur_len_q, cur_len_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                  flush_q, flush_d;
  logic [TID_WIDTH-1:0]  pkt_id_q, pkt_id_d;

  logic                  tlast_cond;
  logic                  s_hs;
  logic                  m_hs;
  logic                  m_last_hs;
  logic                  pkt_start;
  logic [LEN_WIDTH-1:0]  sane_len;

  always_comb begin
    tlast_cond    = (beat_cnt_q == cur_len_q) || flush_q;
    // A non-last beat waits for its successor so a later timeout can still retro-tag it.
    m_axis_tvalid = hold_valid_q && (s_axis_tvalid || tlast_cond);
    m_axis_tlast  = hold_valid_q && tlast_cond;
    m_axis_tdata  = hold_data_q;
    m_axis_tid    = pkt_id_q;
    s_axis_tready = !areset && (!hold_valid_q || m_axis_tready);

    s_hs      = s_axis_tvalid && s_axis_tready;
    m_hs      = m_axis_tvalid && m_axis_tready;
    m_last_hs = m_hs && tlast_cond;
    pkt_start = !hold_valid_q || m_last_hs;
    sane_len  = ((cfg_pkt_len == '0) || (cfg_pkt_len > MAX_LEN)) ? MAX_LEN : cfg_pkt_len;
  end

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    beat_cnt_d   = beat_cnt_q;
    cur_len_d    = cur_len_q;
    idle_cnt_d   = '0;
    flush_d      = flush_q;
    pkt_id_d     = pkt_id_q;

    if (s_hs) begin
      hold_data_d  = s_axis_tdata;
      hold_valid_d = 1'b1;
      if (pkt_start) begin
        beat_cnt_d = LEN_WIDTH'(1);
        cur_len_d  = sane_len;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    if (m_last_hs) begin
      pkt_id_d = pkt_id_q + 1'b1;
      flush_d  = 1'b0;
      if (!s_hs) begin
        hold_valid_d = 1'b0;
        beat_cnt_d   = '0;
      end
    end

    // Idle cycles are only counted while a non-last beat is stranded in the hold register.
    if ((TIMEOUT > 0) && hold_valid_q && !s_axis_tvalid && !tlast_cond) begin
      if (idle_cnt_q + 1'b1 == IDLE_LIMIT) begin
        flush_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      beat_cnt_q   <= '0;
      cur_len_q    <= MAX_LEN;
      idle_cnt_q   <= '0;
      flush_q      <= 1'b0;
      pkt_id_q     <= '0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      beat_cnt_q   <= beat_cnt_d;
      cur_len_q    <= cur_len_d;
      idle_cnt_q   <= idle_cnt_d;
      flush_q      <= flush_d;
      pkt_id_q     <= pkt_id_d;
    end
  end

`ifdef AXIS_PACKETIZER_STATS_EN
  logic [31:0] stat_pkt_cnt_q, stat_pkt_cnt_d;
  logic [31:0] stat_flush_cnt_q, stat_flush_cnt_d;

  always_comb begin
    stat_pkt_cnt_d   = stat_pkt_cnt_q;
    stat_flush_cnt_d = stat_flush_cnt_q;
    if (m_last_hs && (stat_pkt_cnt_q != '1)) begin
      stat_pkt_cnt_d = stat_pkt_cnt_q + 1'b1;
    end
    // A packet counts as timeout-closed when its final beat leaves on the flush flag.
    if (m_last_hs && flush_q && (stat_flush_cnt_q != '1)) begin
      stat_flush_cnt_d = stat_flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_pkt_cnt_q   <= '0;
      stat_flush_cnt_q <= '0;
    end else begin
      stat_pkt_cnt_q   <= stat_pkt_cnt_d;
      stat_flush_cnt_q <= stat_flush_cnt_d;
    end
  end

  assign stat_pkt_cnt   = stat_pkt_cnt_q;
  assign stat_flush_cnt = stat_flush_cnt_q;
`endif

endmodule

// File: tb/tb_axis_packetizer.sv
// Bench for axis_packetizer: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a packet-level reference model.
`timescale 1ns/1ps
module tb_axis_packetizer;
  localparam int DATA_WIDTH  = 32;
  localparam int TID_WIDTH   = 8;
  localparam int MAX_PKT_LEN = 16;
  localparam int LEN_WIDTH   = 5;
  localparam int TIMEOUT     = 4;
  localparam int EW          = 1 + TID_WIDTH + DATA_WIDTH;

  // ---------------- clock / reset / DUT ----------------
  logic                  aclk = 1'b0;
  logic                  areset;
  logic [LEN_WIDTH-1:0]  cfg_pkt_len;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic [TID_WIDTH-1:0]  m_axis_tid;
`ifdef AXIS_PACKETIZER_STATS_EN
  logic [31:0]           stat_pkt_cnt;
  logic [31:0]           stat_flush_cnt;
`endif

  always #5 aclk = ~aclk;

  axis_packetizer #(
    .DATA_WIDTH (DATA_WIDTH),
    .TID_WIDTH  (TID_WIDTH),
    .MAX_PKT_LEN(MAX_PKT_LEN),
    .LEN_WIDTH  (LEN_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_pkt_len  (cfg_pkt_len),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid)
`ifdef AXIS_PACKETIZER_STATS_EN
    ,
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  // ---------------- bookkeeping ----------------
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            ready_mode = 0;  // 0: always ready, 1: random, 2: held low
  logic [EW-1:0] exp_q[$];
  int            hs_cyc_q[$];

  // Packet-level reference: packets close on the programmed length or on a long enough gap.
  int                   m_cnt = 0;
  int                   m_len = 0;
  logic [TID_WIDTH-1:0] m_tid = '0;
  int                   exp_pkts = 0;
  int                   exp_flush = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void model_push(logic [DATA_WIDTH-1:0] d, int cfg, int gap);
    logic last;
    if (m_cnt == 0) m_len = (cfg == 0 || cfg > MAX_PKT_LEN) ? MAX_PKT_LEN : cfg;
    m_cnt++;
    last = (m_cnt == m_len) || (gap >= TIMEOUT);
    exp_q.push_back({last, m_tid, d});
    if (last) begin
      exp_pkts++;
      if (m_cnt != m_len) exp_flush++;
      m_cnt = 0;
      m_tid = m_tid + 1'b1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DATA_WIDTH-1:0] d, input int cfg, input int gap);
    int n;
    n = 0;
    s_axis_tdata  = d;
    cfg_pkt_len   = LEN_WIDTH'(cfg);
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      n++;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL s_accept_timeout: got no s_axis_tready in %0d cycles expected acceptance", n);
        break;
      end
    end
    @(posedge aclk);
    #1;
    model_push(d, cfg, gap);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_idle(input logic [DATA_WIDTH-1:0] d, input int cfg, input int gap);
    send_beat(d, cfg, gap);
    idle(gap);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_s_tready"}, 64'(s_axis_tready), 64'(0));
    check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'(0));
    check({tag, "_m_tlast"},  64'(m_axis_tlast),  64'(0));
    check({tag, "_m_tid"},    64'(m_axis_tid),    64'(0));
`ifdef AXIS_PACKETIZER_STATS_EN
    check({tag, "_stat_pkt"},   64'(stat_pkt_cnt),   64'(0));
    check({tag, "_stat_flush"}, 64'(stat_flush_cnt), 64'(0));
`endif
  endtask

  task automatic check_stats();
`ifdef AXIS_PACKETIZER_STATS_EN
    check("stat_pkt_cnt",   64'(stat_pkt_cnt),   64'(exp_pkts));
    check("stat_flush_cnt", 64'(stat_flush_cnt), 64'(exp_flush));
`endif
  endtask

  // ---------------- downstream ready generator ----------------
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #2;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 3) != 0);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge aclk) begin : monitor
    logic [EW-1:0] e;
    if (!areset && m_axis_tvalid) begin
      if (m_axis_tready) begin
        hs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h tid %0h last %0b expected no beat",
                   m_axis_tdata, m_axis_tid, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          check("beat{last,tid,data}", 64'({m_axis_tlast, m_axis_tid, m_axis_tdata}), 64'(e));
        end
      end else begin
        check("stall_s_tready", 64'(s_axis_tready), 64'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int cfg;
    int gap;
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    cfg_pkt_len   = LEN_WIDTH'(4);
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;

    // Length 4, back-to-back 0..11: three packets with no gap cycles.
    hs_cyc_q.delete();
    for (int i = 0; i < 12; i++) send_idle(DATA_WIDTH'(i), 4, 0);
    wait_drain();
    check("len4_beats_out", 64'(hs_cyc_q.size()), 64'(12));
    if (hs_cyc_q.size() == 12) check("len4_no_bubbles", 64'(hs_cyc_q[11] - hs_cyc_q[0]), 64'(11));

    // Zero and oversize lengths both fall back to MAX_PKT_LEN.
    for (int i = 0; i < 16; i++) send_idle(DATA_WIDTH'(100 + i), 0, 0);
    for (int i = 0; i < 16; i++) send_idle(DATA_WIDTH'(200 + i), 20, 0);
    wait_drain();

    // Timeout: three beats of an 8-beat packet, then silence.
    for (int i = 0; i < 3; i++) begin
      send_beat(DATA_WIDTH'(300 + i), 8, (i == 2) ? TIMEOUT + 10 : 0);
      if (i != 2) idle(0);
    end
    k = 0;
    do begin
      @(negedge aclk);
      k++;
    end while (!m_axis_tvalid && k < 20);
    check("flush_latency", 64'(k), 64'(TIMEOUT + 1));
    check("flush_tlast", 64'(m_axis_tlast), 64'(1));
    @(posedge aclk);
    #1;
    for (int i = 0; i < 8; i++) send_idle(DATA_WIDTH'(310 + i), 8, 0);
    wait_drain();

    // Downstream stall of 10 cycles in the middle of a packet.
    fork
      begin
        for (int i = 0; i < 8; i++) send_idle(DATA_WIDTH'(400 + i), 4, 0);
      end
      begin
        repeat (2) @(posedge aclk);
        ready_mode = 2;
        repeat (10) @(posedge aclk);
        ready_mode = 0;
      end
    join
    wait_drain();

    // Length change on the second beat only affects the next packet.
    send_idle(DATA_WIDTH'(450), 4, 0);
    for (int i = 1; i < 6; i++) send_idle(DATA_WIDTH'(450 + i), 2, 0);
    wait_drain();

    // Randomized lengths, gaps and backpressure.
    ready_mode = 1;
    cfg = 5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) cfg = $urandom_range(0, 20);
      k = $urandom_range(0, 99);
      if (k < 70)      gap = 0;
      else if (k < 88) gap = $urandom_range(1, TIMEOUT - 1);
      else             gap = $urandom_range(TIMEOUT, TIMEOUT + 3);
      if (i == 399) gap = TIMEOUT + 2;
      send_idle($urandom, cfg, gap);
    end
    wait_drain();

    // Single-beat packets; long enough to wrap the packet ID.
    for (int i = 0; i < 300; i++) send_idle($urandom, 1, $urandom_range(0, 1));
    wait_drain();
    ready_mode = 0;
    idle(2);
    check_stats();

    // Reset while beat 2 of a 4-beat packet is held.
    send_idle(DATA_WIDTH'(500), 4, 0);
    send_beat(DATA_WIDTH'(501), 4, 1);
    areset = 1'b1;
    #1;
    exp_q.delete();
    m_cnt     = 0;
    m_tid     = '0;
    exp_pkts  = 0;
    exp_flush = 0;
    check_reset_outputs("midpkt_reset");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) send_idle(DATA_WIDTH'(600 + i), 4, 0);
    wait_drain();
    idle(2);
    check_stats();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion by %0t expected finish", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
